// File: rtl/filt_pkg.sv
// Shared constants and types for the notch-filter datapath and its I2S output stage.
package filt_pkg;

  localparam int FILT_DATA_SIZE = 24;
  localparam int I2S_CLK_DIV    = 4;
  localparam int I2S_SLOT_BITS  = 32;

  typedef logic signed [FILT_DATA_SIZE-1:0] sample_t;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_out_tx_if.sv
// Filter-side sample handshake plus the I2S pins and status flags of i2s_out_tx.
interface i2s_out_tx_if
  import filt_pkg::*;
#(
  parameter int DATA_SIZE = FILT_DATA_SIZE
) ();

  logic [DATA_SIZE-1:0] data_in;
  logic                 data_valid;
  logic                 frame_start;
  logic                 sclk;
  logic                 lrclk;
  logic                 sdata;
  logic                 underrun;
  logic                 overrun;

  modport master (
    output data_in, data_valid,
    input  frame_start, sclk, lrclk, sdata, underrun, overrun
  );

  modport slave (
    input  data_in, data_valid,
    output frame_start, sclk, lrclk, sdata, underrun, overrun
  );

endinterface

// File: rtl/i2s_clkgen.sv
// Bit-clock divider and frame bit sequencer; strobes mark each sclk fall and the frame wrap.
module i2s_clkgen
  import filt_pkg::*;
#(
  parameter int CLK_DIV   = I2S_CLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  localparam int DW = cnt_width(CLK_DIV),
  localparam int CW = cnt_width(2 * SLOT_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          sclk,
  output logic          fall_en,
  output logic [CW-1:0] bit_cnt,
  output logic          frame_wrap
);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(2 * SLOT_BITS - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          div_tc;

  // bit_cnt is the slot position that begins at the current fall (valid with fall_en).
  always_comb begin
    div_tc     = (div_cnt_q == DIV_LAST);
    div_cnt_d  = div_tc ? '0 : div_cnt_q + 1'b1;
    sclk_d     = div_tc ? ~sclk_q : sclk_q;
    fall_en    = div_tc & sclk_q;
    frame_wrap = fall_en & (bit_cnt_q == BIT_LAST);
    bit_cnt    = frame_wrap ? '0 : bit_cnt_q + 1'b1;
    bit_cnt_d  = fall_en ? bit_cnt : bit_cnt_q;
  end

  // Counter parks on the last position so the first fall after reset opens frame 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      bit_cnt_q <= BIT_LAST;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/i2s_out_tx.sv
// Philips I2S transmitter: holds the latest filtered sample and sends it in both slots each frame.
// Build option I2S_OUT_TX_ZERO_ON_UNDERRUN_EN sends silence on underrun instead of repeating the last sample.
module i2s_out_tx
  import filt_pkg::*;
#(
  parameter int DATA_SIZE = FILT_DATA_SIZE,
  parameter int CLK_DIV   = I2S_CLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS
) (
  input logic         clk,
  input logic         reset,
  i2s_out_tx_if.slave bus
);

  localparam int CW = cnt_width(2 * SLOT_BITS);
  localparam int KW = cnt_width(SLOT_BITS);
  localparam logic [CW-1:0] SLOT_LEN = CW'(SLOT_BITS);

  logic          sclk;
  logic          fall_en;
  logic          frame_wrap;
  logic [CW-1:0] bit_cnt;
  logic [KW-1:0] slot_k;
  logic [SLOT_BITS-1:0] slot_bits;
  logic          load_ok;

  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_SIZE-1:0] tx_word_q, tx_word_d;
  slot_e                lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic                 frame_start_q, frame_start_d;
  logic                 underrun_q, underrun_d;
  logic                 overrun_q, overrun_d;

  i2s_clkgen #(
    .CLK_DIV   (CLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .fall_en    (fall_en),
    .bit_cnt    (bit_cnt),
    .frame_wrap (frame_wrap)
  );

  // Slot image: position 0 is the I2S delay bit, then the word MSB first, then zero padding.
  for (genvar gi = 0; gi < SLOT_BITS; gi++) begin : g_slot
    if (gi >= 1 && gi <= DATA_SIZE) begin : g_data
      assign slot_bits[gi] = tx_word_q[DATA_SIZE-gi];
    end else begin : g_pad
      assign slot_bits[gi] = 1'b0;
    end
  end

  always_comb begin
    slot_k  = KW'((bit_cnt >= SLOT_LEN) ? bit_cnt - SLOT_LEN : bit_cnt);
    load_ok = hold_full_q | bus.data_valid;

    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_word_d     = tx_word_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = frame_wrap;
    underrun_d    = 1'b0;
    overrun_d     = overrun_q;

    // A sample landing on the load edge is kept for the next frame and is not an overrun.
    if (bus.data_valid) begin
      hold_d      = bus.data_in;
      hold_full_d = 1'b1;
      if (hold_full_q && !frame_wrap) begin
        overrun_d = 1'b1;
      end
    end

    if (frame_wrap) begin
      if (load_ok) begin
        tx_word_d = hold_q;
        if (!bus.data_valid) begin
          hold_full_d = 1'b0;
        end
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_OUT_TX_ZERO_ON_UNDERRUN_EN
        tx_word_d = '0;
`else
        tx_word_d = tx_word_q;
`endif
      end
    end

    // The load edge itself is slot position 0, so the old tx_word never reaches sdata there.
    if (fall_en) begin
      lrclk_d = (bit_cnt >= SLOT_LEN) ? SLOT_RIGHT : SLOT_LEFT;
      sdata_d = slot_bits[slot_k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_word_q     <= '0;
      lrclk_q       <= SLOT_LEFT;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_word_q     <= tx_word_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.sclk        = sclk;
  assign bus.lrclk       = lrclk_q;
  assign bus.sdata       = sdata_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underrun    = underrun_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_out_tx.sv
// Directed/random bench for i2s_out_tx: an I2S receiver model rebuilds each frame and checks it.
module tb_i2s_out_tx;
  import filt_pkg::*;

  localparam int DS = 24;
  localparam int CD = 2;
  localparam int SB = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2s_out_tx_if #(.DATA_SIZE(DS)) bus ();

  i2s_out_tx #(
    .DATA_SIZE (DS),
    .CLK_DIV   (CD),
    .SLOT_BITS (SB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] left;
    logic [31:0] right;
    int          len;
    int          lr_high;
    int          rises;
    logic        ur;
    logic        bad;
  } frame_t;

  frame_t      frames [0:127];
  int          fs_cnt, done_cnt, cyc, last_rise, cur_len, cur_lrh, cur_rises;
  logic        cur_ur, cur_bad, active, prev_sclk;
  logic [31:0] cur_left, cur_right;
  int          checks = 0;
  int          failures = 0;

  // Receiver: latches sdata/lrclk on every sclk rise, one record per frame_start-to-frame_start.
  always @(negedge clk) begin
    prev_sclk <= bus.sclk;
    cyc       <= cyc + 1;
    if (reset) begin
      fs_cnt    <= 0;
      done_cnt  <= 0;
      active    <= 1'b0;
      last_rise <= -1;
    end else begin
      cur_len <= cur_len + 1;
      if (bus.frame_start) begin
        if (active && fs_cnt >= 1 && fs_cnt <= 128) begin
          frames[fs_cnt-1] <= '{left: cur_left, right: cur_right, len: cur_len,
                                 lr_high: cur_lrh, rises: cur_rises, ur: cur_ur, bad: cur_bad};
          done_cnt <= done_cnt + 1;
        end
        active    <= 1'b1;
        fs_cnt    <= fs_cnt + 1;
        cur_len   <= 1;
        cur_lrh   <= bus.lrclk ? 1 : 0;
        cur_rises <= 0;
        cur_ur    <= bus.underrun;
        cur_bad   <= bus.sclk;
        cur_left  <= '0;
        cur_right <= '0;
      end else if (active) begin
        cur_lrh <= cur_lrh + (bus.lrclk ? 1 : 0);
        if (bus.underrun) cur_ur <= 1'b1;
        if (bus.sclk && !prev_sclk) begin
          if (cur_rises < 32) cur_left <= {cur_left[30:0], bus.sdata};
          else if (cur_rises < 64) cur_right <= {cur_right[30:0], bus.sdata};
          cur_rises <= cur_rises + 1;
          if (bus.lrclk !== (cur_rises >= 32)) cur_bad <= 1'b1;
          if (last_rise >= 0 && (cyc - last_rise) != 2 * CD) cur_bad <= 1'b1;
          last_rise <= cyc;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Slot as a receiver sees it: delay bit, sample MSB first, zero padding to 32 bits.
  function automatic logic [31:0] slot_word(input logic [23:0] v);
    return {1'b0, v, 7'b0};
  endfunction

  task automatic check_outputs_reset(input string tag);
    chk({tag, "_sclk"}, 64'(bus.sclk), 64'd0);
    chk({tag, "_lrclk"}, 64'(bus.lrclk), 64'd0);
    chk({tag, "_sdata"}, 64'(bus.sdata), 64'd0);
    chk({tag, "_frame_start"}, 64'(bus.frame_start), 64'd0);
    chk({tag, "_underrun"}, 64'(bus.underrun), 64'd0);
    chk({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
  endtask

  // Assert reset for two cycles, then measure cycles from release to the first frame_start.
  task automatic do_reset(input string tag);
    int cnt;
    bit found;
    reset = 1'b1;
    @(negedge clk);
    check_outputs_reset(tag);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.frame_start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout({tag, "_first_frame"});
    else chk({tag, "_latency"}, 64'(cnt), 64'd4);
    $display("reset %s: first frame_start %0d cycles after release", tag, cnt);
  endtask

  task automatic sync(output int n);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.frame_start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_timeout("sync_frame_start");
    #1;
    n = fs_cnt - 1;
  endtask

  task automatic send(input logic [23:0] v);
    @(negedge clk);
    bus.data_valid = 1'b1;
    bus.data_in    = v;
    @(negedge clk);
    bus.data_valid = 1'b0;
    $display("send sample %06h", v);
  endtask

  task automatic get_frame(input int n, output frame_t f, output bit ok);
    int waited;
    waited = 0;
    while (done_cnt <= n && waited < 900) begin
      @(negedge clk);
      #1;
      waited++;
    end
    ok = (done_cnt > n);
    f = frames[n];
  endtask

  task automatic check_frame(input string tag, input int n, input logic [23:0] exp, input logic exp_ur);
    frame_t f;
    bit ok;
    get_frame(n, f, ok);
    if (!ok) begin
      fail_timeout({tag, "_frame"});
    end else begin
      $display("frame %0d %s: left=%08h right=%08h underrun=%0b expect sample %06h",
               n, tag, f.left, f.right, f.ur, exp);
      chk({tag, "_left"}, 64'(f.left), 64'(slot_word(exp)));
      chk({tag, "_right"}, 64'(f.right), 64'(slot_word(exp)));
      chk({tag, "_underrun"}, 64'(f.ur), 64'(exp_ur));
    end
  endtask

  task automatic check_timing(input string tag, input int n);
    frame_t f;
    bit ok;
    get_frame(n, f, ok);
    if (!ok) begin
      fail_timeout({tag, "_timing"});
    end else begin
      $display("frame %0d %s: len=%0d lr_high=%0d rises=%0d bad=%0b", n, tag, f.len, f.lr_high, f.rises, f.bad);
      chk({tag, "_len"}, 64'(f.len), 64'(2 * SB * 2 * CD));
      chk({tag, "_lr_high"}, 64'(f.lr_high), 64'(SB * 2 * CD));
      chk({tag, "_rises"}, 64'(f.rises), 64'(2 * SB));
      chk({tag, "_sclk_lr_ok"}, 64'(f.bad), 64'd0);
    end
  endtask

  initial begin
    int n, m;
    logic [23:0] r1, r2, s, exp_ur_word;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;

    // Reset, then idle frames: silence, underrun every frame, nominal timing.
    do_reset("init");
    check_timing("idle0", 0);
    check_frame("idle0", 0, 24'h0, 1'b1);
    check_frame("idle1", 1, 24'h0, 1'b1);
    check_timing("idle1", 1);

    // Single known pattern.
    sync(n);
    repeat (20) @(negedge clk);
    send(24'hA5F00F);
    check_frame("a5f00f", n + 1, 24'hA5F00F, 1'b0);

    // Sign and MSB extremes in consecutive frames.
    sync(n);
    repeat (10) @(negedge clk);
    send(24'h800000);
    sync(m);
    send(24'h7FFFFF);
    check_frame("neg_full", m, 24'h800000, 1'b0);
    check_frame("pos_full", m + 1, 24'h7FFFFF, 1'b0);

    // Sample arriving in the frame_start cycle goes to the following frame.
    r1 = 24'($urandom());
    r2 = 24'($urandom());
    sync(n);
    send(r1);
    sync(m);
    bus.data_valid = 1'b1;
    bus.data_in    = r2;
    @(negedge clk);
    bus.data_valid = 1'b0;
    $display("send sample %06h in frame_start cycle", r2);
    check_frame("coinc_old", m, r1, 1'b0);
    check_frame("coinc_new", m + 1, r2, 1'b0);
    chk("coinc_overrun", 64'(bus.overrun), 64'd0);

    // Random samples at random points inside a frame.
    for (int i = 0; i < 3; i++) begin
      r1 = 24'($urandom());
      sync(n);
      repeat ($urandom_range(3, 200)) @(negedge clk);
      send(r1);
      check_frame($sformatf("rand%0d", i), n + 1, r1, 1'b0);
    end

    // Underrun frame content: silence or repeat of the last sample.
    s = 24'($urandom()) | 24'h000100;
    sync(n);
    send(s);
    check_frame("ur_src", n + 1, s, 1'b0);
`ifdef I2S_OUT_TX_ZERO_ON_UNDERRUN_EN
    exp_ur_word = 24'h0;
`else
    exp_ur_word = s;
`endif
    check_frame("ur_fill", n + 2, exp_ur_word, 1'b1);

    // Two samples in one frame: sticky overrun, newest sample wins.
    chk("overrun_pre", 64'(bus.overrun), 64'd0);
    sync(n);
    send(24'h111111);
    repeat (5) @(negedge clk);
    send(24'h222222);
    @(negedge clk);
    chk("overrun_set", 64'(bus.overrun), 64'd1);
    check_frame("overrun_send", n + 1, 24'h222222, 1'b0);
    chk("overrun_sticky", 64'(bus.overrun), 64'd1);

    // Reset in bit 10 of the left slot: clean restart from frame 0.
    sync(n);
    repeat (41) @(negedge clk);
    do_reset("midframe");
    check_frame("post_reset", 0, 24'h0, 1'b1);
    check_timing("post_reset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
